// File: rtl/self_trigger_discriminator.sv
// Threshold/hysteresis pulse discriminator with minimum-width trigger and post-pulse dead time.
// Define TRIG_PEAK_CAPTURE_EN to capture the pulse maximum on peak; otherwise peak reads 0.
module self_trigger_discriminator #(
  parameter int MIN_WIDTH = 4,
  parameter int HOLDOFF   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [15:0] x,
  input  logic signed [15:0] threshold,
  input  logic        [7:0]  hysteresis,
  output logic               trigger,
  output logic               busy,
  output logic               valid,
  output logic signed [15:0] peak,
  output logic        [11:0] width
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_ABOVE  = 2'd1;
  localparam logic [1:0]  ST_HOLD   = 2'd2;
  localparam logic [11:0] MIN_W     = 12'(MIN_WIDTH);
  localparam logic [11:0] CNT_MAX   = 12'd4095;
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 1);

  logic signed [15:0] x_reg_q, x_reg_d;
  logic               en_reg_q;
  logic [1:0]         state_q, state_d;
  logic [11:0]        cnt_q, cnt_d;
  logic [15:0]        hcnt_q, hcnt_d;
  logic               trigger_q, trigger_d;
  logic               valid_q, valid_d;
  logic [11:0]        width_q, width_d;
  logic signed [16:0] release_lvl;
  logic               above_rel;

  // One bit of headroom keeps threshold - hysteresis from wrapping near -32768.
  assign release_lvl = $signed({threshold[15], threshold}) - $signed({9'd0, hysteresis});
  assign above_rel   = $signed({x_reg_q[15], x_reg_q}) > release_lvl;

`ifdef TRIG_PEAK_CAPTURE_EN
  logic signed [15:0] pk_q, pk_d;
  logic signed [15:0] peak_q, peak_d;
`endif

  always_comb begin
    x_reg_d   = enable ? x : x_reg_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    width_d   = width_q;
    trigger_d = 1'b0;
    valid_d   = 1'b0;
`ifdef TRIG_PEAK_CAPTURE_EN
    pk_d      = pk_q;
    peak_d    = peak_q;
`endif
    if (en_reg_q) begin
      case (state_q)
        ST_IDLE: begin
          if (x_reg_q > threshold) begin
            state_d   = ST_ABOVE;
            cnt_d     = 12'd1;
            trigger_d = (MIN_W == 12'd1);
`ifdef TRIG_PEAK_CAPTURE_EN
            pk_d      = x_reg_q;
`endif
          end
        end
        ST_ABOVE: begin
          if (above_rel) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 12'd1;
            trigger_d = ((cnt_q + 12'd1) == MIN_W);
`ifdef TRIG_PEAK_CAPTURE_EN
            if (x_reg_q > pk_q) pk_d = x_reg_q;
`endif
          end else begin
            // A pulse that never reached MIN_WIDTH is dropped without a report.
            if (cnt_q >= MIN_W) begin
              valid_d = 1'b1;
              width_d = cnt_q;
              state_d = ST_HOLD;
              hcnt_d  = '0;
`ifdef TRIG_PEAK_CAPTURE_EN
              peak_d  = pk_q;
`endif
            end else begin
              state_d = ST_IDLE;
            end
            cnt_d = '0;
          end
        end
        ST_HOLD: begin
          if (hcnt_q == HOLD_LAST) begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg_q   <= '0;
      en_reg_q  <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      trigger_q <= 1'b0;
      valid_q   <= 1'b0;
      width_q   <= '0;
    end else begin
      x_reg_q   <= x_reg_d;
      en_reg_q  <= enable;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      trigger_q <= trigger_d;
      valid_q   <= valid_d;
      width_q   <= width_d;
    end
  end

`ifdef TRIG_PEAK_CAPTURE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pk_q   <= '0;
      peak_q <= '0;
    end else begin
      pk_q   <= pk_d;
      peak_q <= peak_d;
    end
  end
  assign peak = peak_q;
`else
  assign peak = '0;
`endif

  assign trigger = trigger_q;
  assign valid   = valid_q;
  assign width   = width_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_self_trigger_discriminator.sv
// Bench for self_trigger_discriminator: directed scenarios plus a randomized stream
// compared cycle by cycle against a sample-level pulse model.
module tb_self_trigger_discriminator;
  localparam int MINW = 4;
  localparam int HOLD = 64;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic signed [15:0] x;
  logic signed [15:0] threshold;
  logic        [7:0]  hysteresis;
  logic               trigger, busy, valid;
  logic signed [15:0] peak;
  logic        [11:0] width;

  self_trigger_discriminator #(.MIN_WIDTH(MINW), .HOLDOFF(HOLD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .x(x), .threshold(threshold),
    .hysteresis(hysteresis), .trigger(trigger), .busy(busy), .valid(valid),
    .peak(peak), .width(width)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: run = samples in current pulse (0 = none), best = max seen, dead = dead-time left.
  int                 run, best, dead, px;
  logic               pen;
  logic               exp_trig, exp_val, exp_busy;
  logic signed [15:0] exp_peak;
  logic        [11:0] exp_width;

  task automatic model_clear();
    run = 0; best = 0; dead = 0; px = 0; pen = 1'b0;
    exp_trig = 1'b0; exp_val = 1'b0; exp_busy = 1'b0;
    exp_peak = '0; exp_width = '0;
  endtask

  // Judge the previously accepted sample against the levels present at this edge.
  task automatic model_sample();
    int rel;
    exp_trig = 1'b0;
    exp_val  = 1'b0;
    if (pen) begin
      rel = int'(threshold) - int'(hysteresis);
      if (dead > 0) begin
        dead = dead - 1;
      end else if (run == 0) begin
        if (px > int'(threshold)) begin
          run = 1; best = px;
          if (MINW == 1) exp_trig = 1'b1;
        end
      end else if (px > rel) begin
        if (run < 4095) run = run + 1;
        if (px > best) best = px;
        if (run == MINW) exp_trig = 1'b1;
      end else begin
        if (run >= MINW) begin
          exp_val   = 1'b1;
          exp_width = 12'(run);
`ifdef TRIG_PEAK_CAPTURE_EN
          exp_peak  = 16'(best);
`endif
          dead = HOLD;
        end
        run = 0;
      end
    end
    exp_busy = (run > 0) || (dead > 0);
  endtask

  task automatic step(input logic en, input int xv);
    enable = en;
    x      = 16'(xv);
    model_sample();
    pen = en;
    if (en) px = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 200 && (busy || exp_busy); i++) step(1'b1, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; x = 16'sd500; threshold = 16'sd100; hysteresis = 8'd10;
    model_clear();
    #1;
    if ({trigger, valid, busy, peak, width} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_async got %b/%b/%b/%0d/%0d want all 0", trigger, valid, busy, peak, width);
    end
    n_tests++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step(1'b1, 0);
    if ({trigger, valid, busy, peak, width} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_idle got %b/%b/%b/%0d/%0d want all 0", trigger, valid, busy, peak, width);
    end
    n_tests++;
  endtask

  task automatic test_basic();
    int trig_idx = -1, val_idx = -1, ntrig = 0, nbusy = 0;
    int val_w = 0;
    threshold = 16'sd100; hysteresis = 8'd10;
    for (int i = 0; i < 80; i++) begin
      step(1'b1, (i >= 1 && i <= 6) ? 200 : 0);
      if ({trigger, valid, busy, peak, width} !== {exp_trig, exp_val, exp_busy, exp_peak, exp_width}) begin
        n_fail++;
        $display("FAIL basic@%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", i, trigger, valid, busy,
                 peak, width, exp_trig, exp_val, exp_busy, exp_peak, exp_width);
      end
      n_tests++;
      if (trigger) begin ntrig++; trig_idx = i; end
      if (valid) begin val_idx = i; val_w = int'(width); end
      if (val_idx >= 0 && busy) nbusy++;
    end
    if (ntrig !== 1 || trig_idx !== 5) begin
      n_fail++; $display("FAIL basic_trig_latency got n=%0d at %0d want n=1 at 5", ntrig, trig_idx);
    end
    n_tests++;
    if (val_idx !== 8 || val_w !== 6) begin
      n_fail++; $display("FAIL basic_valid got idx=%0d w=%0d want idx=8 w=6", val_idx, val_w);
    end
    n_tests++;
    if (nbusy !== HOLD) begin
      n_fail++; $display("FAIL basic_holdoff got %0d busy samples want %0d", nbusy, HOLD);
    end
    n_tests++;
  endtask

  task automatic test_glitch();
    int nev = 0;
    threshold = 16'sd100; hysteresis = 8'd10;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i < 3) ? 150 : 0);
      if ({trigger, valid, busy, peak, width} !== {exp_trig, exp_val, exp_busy, exp_peak, exp_width}) begin
        n_fail++;
        $display("FAIL glitch@%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", i, trigger, valid, busy,
                 peak, width, exp_trig, exp_val, exp_busy, exp_peak, exp_width);
      end
      n_tests++;
      if (trigger || valid) nev++;
    end
    if (nev !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL glitch_reject got events=%0d busy=%b want 0/0", nev, busy);
    end
    n_tests++;
  endtask

  task automatic test_hysteresis();
    int seq_a[8] = '{120, 95, 120, 85, 0, 0, 0, 0};
    int seq_b[8] = '{120, 95, 120, 120, 85, 0, 0, 0};
    int nval_a = 0, nval_b = 0, wb = 0;
    threshold = 16'sd100; hysteresis = 8'd10;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, seq_a[i]);
      if ({trigger, valid, busy, peak, width} !== {exp_trig, exp_val, exp_busy, exp_peak, exp_width}) begin
        n_fail++;
        $display("FAIL hyst_a@%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", i, trigger, valid, busy,
                 peak, width, exp_trig, exp_val, exp_busy, exp_peak, exp_width);
      end
      n_tests++;
      if (valid || trigger) nval_a++;
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, seq_b[i]);
      if ({trigger, valid, busy, peak, width} !== {exp_trig, exp_val, exp_busy, exp_peak, exp_width}) begin
        n_fail++;
        $display("FAIL hyst_b@%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", i, trigger, valid, busy,
                 peak, width, exp_trig, exp_val, exp_busy, exp_peak, exp_width);
      end
      n_tests++;
      if (valid) begin nval_b++; wb = int'(width); end
    end
    if (nval_a !== 0 || nval_b !== 1 || wb !== 4) begin
      n_fail++; $display("FAIL hyst_summary got a=%0d b=%0d w=%0d want 0/1/4", nval_a, nval_b, wb);
    end
    n_tests++;
    settle();
  endtask

  task automatic test_min_threshold();
    int ntrig = 0, nval = 0;
    threshold = -16'sd32768; hysteresis = 8'd255;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) hysteresis = 8'd0;
      step(1'b1, (i < 8) ? -32760 : -32768);
      if ({trigger, valid, busy, peak, width} !== {exp_trig, exp_val, exp_busy, exp_peak, exp_width}) begin
        n_fail++;
        $display("FAIL minthr@%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", i, trigger, valid, busy,
                 peak, width, exp_trig, exp_val, exp_busy, exp_peak, exp_width);
      end
      n_tests++;
      if (trigger) ntrig++;
      if (valid) nval++;
    end
    if (ntrig !== 1 || nval !== 1) begin
      n_fail++; $display("FAIL minthr_summary got trig=%0d valid=%0d want 1/1", ntrig, nval);
    end
    n_tests++;
    settle();
  endtask

  task automatic test_reset_mid();
    int nval = 0;
    threshold = 16'sd100; hysteresis = 8'd10;
    for (int i = 0; i < 6; i++) step(1'b1, (i >= 1) ? 200 : 0);
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre got busy=%b want 1", busy);
    end
    n_tests++;
    #2 reset = 1'b1;
    #1;
    if ({trigger, valid, busy, peak, width} !== 31'd0) begin
      n_fail++;
      $display("FAIL rstmid_async got %b/%b/%b/%0d/%0d want all 0", trigger, valid, busy, peak, width);
    end
    n_tests++;
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, (i >= 4 && i <= 9) ? 200 : 0);
      if ({trigger, valid, busy, peak, width} !== {exp_trig, exp_val, exp_busy, exp_peak, exp_width}) begin
        n_fail++;
        $display("FAIL rstmid@%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", i, trigger, valid, busy,
                 peak, width, exp_trig, exp_val, exp_busy, exp_peak, exp_width);
      end
      n_tests++;
      if (valid) nval++;
    end
    if (nval !== 1 || width !== 12'd6) begin
      n_fail++; $display("FAIL rstmid_next got valid=%0d w=%0d want 1/6", nval, width);
    end
    n_tests++;
    settle();
  endtask

  task automatic test_enable_gaps();
    int nval = 0;
    threshold = 16'sd100; hysteresis = 8'd10;
    step(1'b1, 0);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 1) step(1'b0, int'($urandom_range(1000)) - 500);
      else step(1'b1, (i < 12) ? 210 - i : 0);
      if ({trigger, valid, busy, peak, width} !== {exp_trig, exp_val, exp_busy, exp_peak, exp_width}) begin
        n_fail++;
        $display("FAIL gaps@%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", i, trigger, valid, busy,
                 peak, width, exp_trig, exp_val, exp_busy, exp_peak, exp_width);
      end
      n_tests++;
      if (valid) nval++;
    end
    if (nval !== 1 || width !== 12'd6) begin
      n_fail++; $display("FAIL gaps_width got valid=%0d w=%0d want 1/6", nval, width);
    end
    n_tests++;
    settle();
  endtask

  task automatic test_random();
    int lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) threshold = 16'(int'($urandom_range(100)) - 50);
      if ($urandom_range(39) == 0) hysteresis = 8'($urandom_range(60));
      if ($urandom_range(4) == 0) lvl = int'($urandom_range(400)) - 200;
      if ($urandom_range(200) == 0) lvl = ($urandom_range(1) == 1) ? 32767 : -32768;
      step(($urandom_range(3) != 0), lvl);
      if ({trigger, valid, busy, peak, width} !== {exp_trig, exp_val, exp_busy, exp_peak, exp_width}) begin
        n_fail++;
        $display("FAIL random@%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d", i, trigger, valid, busy,
                 peak, width, exp_trig, exp_val, exp_busy, exp_peak, exp_width);
      end
      n_tests++;
      if (trigger && valid) begin
        n_fail++; $display("FAIL random_exclusive@%0d got trigger=1 valid=1 want not both", i);
      end
      n_tests++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_hysteresis();
    test_min_threshold();
    test_reset_mid();
    test_enable_gaps();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
